fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Write-side pointer and full-flag controller for the async FIFO.
- Sits directly upstream of the FIFO memory in the write clock domain and produces its winc qualification inputs: wfull and waddr.
- Maintains a binary write pointer and a Gray-coded write pointer (wptr) that is exported to the read-side synchronizer.
- Compares against the already-synchronized Gray read pointer to produce full, almost-full, fill level and overflow status.

Parameters:
- ADDR_WIDTH, 3, memory address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 6, fill level at or above which walmost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
- wclk  in  1  write-domain clock; all state updates on its rising edge.
- wrst  in  1  asynchronous, active-high reset.
- winc  in  1  write request from producer.
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into wclk.
- wovf_clr  in  1  clears the sticky overflow flag.
- waddr  out  ADDR_WIDTH  write address to memory; equals low bits of the binary write pointer.
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-side synchronizer.
- wfull  out  1  FIFO full, registered.
- walmost_full  out  1  level >= AFULL_THRESH, registered.
- wlevel  out  ADDR_WIDTH+1  fill level as seen from the write domain, registered.
- wovf  out  1  sticky overflow flag.

Behaviour:
- Reset: the async assert of wrst clears wbin, wptr, waddr, wfull, walmost_full, wlevel and wovf to 0. Release is synchronous to wclk (external reset synchronizer). Reset mid-operation discards all pointer state immediately.
- Push: push = winc & ~wfull. wbin_next = wbin + push, modulo 2**(ADDR_WIDTH+1). Gray conversion: wgray_next = (wbin_next >> 1) ^ wbin_next.
- Each edge:
  - wbin <= wbin_next
  - wptr <= wgray_next
  - waddr follows wbin[ADDR_WIDTH-1:0]
- Latency: waddr/wptr advance one cycle after the accepted winc. The memory writes at the current waddr in the same cycle as push.
- Full: wfull <= (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
  - Asserts on the edge of the push that fills the FIFO. No extra cycle of latency.
  - Deasserts one edge after wq2_rptr advances.
  - Conservative: a stale wq2_rptr only delays deassertion and never causes a false not-full.
- Level:
  - rbin_sync = Gray-to-binary of wq2_rptr; MSB copied, each lower bit = XOR of the higher bits.
  - wlevel <= wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1). Range 0..2**ADDR_WIDTH.
  - walmost_full <= (level_next >= AFULL_THRESH).
  - wfull implies wlevel == 2**ADDR_WIDTH.
- Overflow: winc & wfull sets wovf and is otherwise ignored; pointers are unchanged.
  - wovf_clr clears wovf.
  - Simultaneous set and clear in the same cycle: set wins.
- Wrap-around: wbin wraps from 2**(ADDR_WIDTH+1)-1 to 0 with no special case. Full/level arithmetic remains correct across the wrap.
- Simultaneous push and read-pointer advance in one cycle: both are applied and the level is unchanged.
- No state machine beyond the pointer registers. Purely one-clock, with no combinational path from wq2_rptr to any output.

Optional Feature:
- Macro: FIFO_WR_OVF_CNT_EN.
- When defined:
  - Adds output wovf_cnt [7:0], reset to 0.
  - Increments on each cycle where winc & wfull, saturating at 255.
  - Cleared by wovf_clr; a same-cycle increment is lost in favour of the clear.
- When undefined: the port and counter are absent and wovf behaves as above.

Test Plan:
- Reset: assert wrst mid-cycle with wq2_rptr=0 -> outputs are 0 immediately, without waiting for a wclk edge.
- Fill (ADDR_WIDTH=3, wq2_rptr=0), 8 consecutive winc:
  - waddr steps 0..7.
  - wptr steps 0,1,3,2,6,7,5,4, then 0xC after the 8th edge.
  - walmost_full=1 after the 6th push.
  - wfull=1 and wlevel=8 after the 8th push.
- Overflow: with the FIFO full, pulse winc -> wptr stays 0xC and wovf=1. Pulse wovf_clr -> wovf=0. With FIFO_WR_OVF_CNT_EN, 300 overflow cycles -> wovf_cnt=255.
- Drain from full: set wq2_rptr=0x1 -> next edge wfull=0, wlevel=7. Set wq2_rptr=0x3 -> walmost_full stays 1 (level 6). Set wq2_rptr=0x2 -> walmost_full=0 (level 5).
- Wrap: alternate push with matching wq2_rptr advance for 20 pushes -> wptr returns through 0 after 16 pushes, and wlevel stays at 0 or 1 (never 8); wfull never asserts.
- Simultaneous: at level 7, push while wq2_rptr advances by one in the same cycle -> wlevel stays 7 and wfull=0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write side: binary/Gray write pointer, full, almost-full, level, overflow.
// Optional saturating overflow counter enabled by FIFO_WR_OVF_CNT_EN.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   input  logic                  wovf_clr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  wovf
`ifdef FIFO_WR_OVF_CNT_EN
  ,output logic [7:0]            wovf_cnt
`endif
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] rbin_sync;
   logic [PW-1:0] level_next;
   logic [PW-1:0] full_cmp;
   logic          push;
   logic          ovf_set;

   assign push       = winc & ~wfull;
   assign ovf_set    = winc & wfull;
   assign wbin_next  = wbin + PW'(push);
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;
   assign level_next = wbin_next - rbin_sync;
   assign waddr      = wbin[ADDR_WIDTH-1:0];

   // Full when the write pointer is one lap ahead: top two Gray bits inverted.
   assign full_cmp = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                      wq2_rptr[ADDR_WIDTH-2:0]};

   always_comb begin
      rbin_sync = '0;
      for (int i = 0; i < PW; i++)
         rbin_sync[i] = ^(wq2_rptr >> i);
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
      end else begin
         wbin         <= wbin_next;
         wptr         <= wgray_next;
         wfull        <= (wgray_next == full_cmp);
         walmost_full <= (level_next >= PW'(AFULL_THRESH));
         wlevel       <= level_next;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst)
         wovf <= 1'b0;
      else if (ovf_set)
         wovf <= 1'b1;
      else if (wovf_clr)
         wovf <= 1'b0;
   end

`ifdef FIFO_WR_OVF_CNT_EN
   // Clear beats a same-cycle increment; count saturates at 255.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst)
         wovf_cnt <= '0;
      else if (wovf_clr)
         wovf_cnt <= '0;
      else if (ovf_set && wovf_cnt != 8'hFF)
         wovf_cnt <= wovf_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// Model tracks absolute write/read counts; expected outputs queued per cycle.
module tb_fifo_wr_ctrl;

   logic       wclk = 1'b0;
   logic       wrst;
   logic       winc;
   logic [3:0] wq2_rptr;
   logic       wovf_clr;
   logic [2:0] waddr;
   logic [3:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [3:0] wlevel;
   logic       wovf;
`ifdef FIFO_WR_OVF_CNT_EN
   logic [7:0] wovf_cnt;
`endif

   fifo_wr_ctrl #(
      .ADDR_WIDTH   (3),
      .AFULL_THRESH (6)
   ) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .winc         (winc),
      .wq2_rptr     (wq2_rptr),
      .wovf_clr     (wovf_clr),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
`ifdef FIFO_WR_OVF_CNT_EN
     ,.wovf_cnt     (wovf_cnt)
`endif
   );

   always #5 wclk = ~wclk;

   typedef struct {
      int addr;
      int ptr;
      int full;
      int afull;
      int lvl;
      int ovf;
      int cnt;
   } exp_t;

   exp_t sbq[$];
   int   vecs = 0;
   int   errs = 0;

   int   m_wcnt = 0;
   int   m_full = 0;
   int   m_ovf  = 0;
   int   m_cnt  = 0;

   task automatic check(input string tag, input int got, input int exp);
      vecs++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] gray(input int v);
      logic [3:0] b;
      b = 4'(v);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m_wcnt = 0;
      m_full = 0;
      m_ovf  = 0;
      m_cnt  = 0;
   endtask

   // One cycle: drive, queue expected state after the edge, then compare.
   task automatic step(input bit inc, input int rc, input bit clr);
      exp_t e;
      exp_t g;
      int   lvl;
      winc     = inc;
      wovf_clr = clr;
      wq2_rptr = gray(rc);
      if (inc && m_full != 0)
         m_ovf = 1;
      else if (clr)
         m_ovf = 0;
      if (clr)
         m_cnt = 0;
      else if (inc && m_full != 0 && m_cnt < 255)
         m_cnt++;
      if (inc && m_full == 0)
         m_wcnt++;
      lvl    = m_wcnt - rc;
      m_full = (lvl == 8) ? 1 : 0;
      e.addr  = m_wcnt % 8;
      e.ptr   = int'(gray(m_wcnt));
      e.full  = m_full;
      e.afull = (lvl >= 6) ? 1 : 0;
      e.lvl   = lvl;
      e.ovf   = m_ovf;
      e.cnt   = m_cnt;
      sbq.push_back(e);
      @(posedge wclk);
      #1;
      if (sbq.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         g = sbq.pop_front();
         check("waddr", int'(waddr), g.addr);
         check("wptr", int'(wptr), g.ptr);
         check("wfull", int'(wfull), g.full);
         check("walmost_full", int'(walmost_full), g.afull);
         check("wlevel", int'(wlevel), g.lvl);
         check("wovf", int'(wovf), g.ovf);
`ifdef FIFO_WR_OVF_CNT_EN
         check("wovf_cnt", int'(wovf_cnt), g.cnt);
`endif
      end
      winc     = 1'b0;
      wovf_clr = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_waddr"}, int'(waddr), 0);
      check({tag, "_wptr"}, int'(wptr), 0);
      check({tag, "_wfull"}, int'(wfull), 0);
      check({tag, "_afull"}, int'(walmost_full), 0);
      check({tag, "_wlevel"}, int'(wlevel), 0);
      check({tag, "_wovf"}, int'(wovf), 0);
`ifdef FIFO_WR_OVF_CNT_EN
      check({tag, "_cnt"}, int'(wovf_cnt), 0);
`endif
   endtask

   int gseq [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
   int rc;

   initial begin
      wrst     = 1'b1;
      winc     = 1'b0;
      wovf_clr = 1'b0;
      wq2_rptr = '0;
      #1;
      check_zero("rst0");
      @(posedge wclk);
      @(posedge wclk);
      #1;
      wrst = 1'b0;

      // Fill from empty with the read pointer parked at 0
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 0, 1'b0);
         check("fill_wptr_seq", int'(wptr), gseq[i]);
         check("fill_afull", int'(walmost_full), (i >= 5) ? 1 : 0);
      end
      check("full_lvl8", int'(wlevel), 8);

      // Overflow while full, then clear
      step(1'b1, 0, 1'b0);
      step(1'b1, 0, 1'b0);
      check("ovf_wptr_hold", int'(wptr), 12);
      step(1'b0, 0, 1'b1);
      check("ovf_clr", int'(wovf), 0);
`ifdef FIFO_WR_OVF_CNT_EN
      for (int i = 0; i < 300; i++)
         step(1'b1, 0, 1'b0);
      check("cnt_sat", int'(wovf_cnt), 255);
`endif
      // Set and clear together: set wins for the flag
      step(1'b1, 0, 1'b1);
      check("ovf_set_wins", int'(wovf), 1);
      step(1'b0, 0, 1'b1);

      // Drain from full
      step(1'b0, 1, 1'b0);
      check("drain_lvl7", int'(wlevel), 7);
      step(1'b0, 2, 1'b0);
      check("drain_afull6", int'(walmost_full), 1);
      step(1'b0, 3, 1'b0);
      check("drain_afull5", int'(walmost_full), 0);

      // Up to level 7, then push with a simultaneous read advance
      step(1'b1, 3, 1'b0);
      step(1'b1, 3, 1'b0);
      step(1'b1, 4, 1'b0);
      check("simul_lvl7", int'(wlevel), 7);
      check("simul_nofull", int'(wfull), 0);

      // Drain to empty, then lock-step push/read across the pointer wrap
      step(1'b0, 10, 1'b0);
      step(1'b0, 11, 1'b0);
      rc = 11;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, rc, 1'b0);
         check("wrap_lvl1", int'(wlevel), 1);
         check("wrap_nofull", int'(wfull), 0);
         rc++;
         step(1'b0, rc, 1'b0);
         check("wrap_lvl0", int'(wlevel), 0);
      end

      // Mid-cycle asynchronous reset with state in flight
      step(1'b1, rc, 1'b0);
      step(1'b1, rc, 1'b0);
      #3;
      wrst     = 1'b1;
      wq2_rptr = '0;
      #1;
      check_zero("rst_mid");
      model_reset();
      @(posedge wclk);
      #1;
      wrst = 1'b0;
      step(1'b1, 0, 1'b0);
      check("post_rst_wptr", int'(wptr), 1);

      check("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
